// File: rtl/act_s2_feeder_pkg.sv
// Shared definitions for the ACT S2 feeder slice.
//   state_e     : feeder FSM states
//   SEL_*       : bit positions of {A1,B1,A0,B0} inside a select nibble
//   cmd_width() : packed command record width ({rep, sel, d11, d10, d01, d00})
package act_s2_feeder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam int unsigned SEL_A1 = 3;
  localparam int unsigned SEL_B1 = 2;
  localparam int unsigned SEL_A0 = 1;
  localparam int unsigned SEL_B0 = 0;

  function automatic int unsigned cmd_width(input int unsigned bits, input int unsigned rep_w);
    return 4 * bits + 4 + rep_w;
  endfunction

endpackage

// File: rtl/act_cmd_fifo.sv
// Synchronous command FIFO for the ACT S2 feeder.
//   clock, reset     : rising-edge clock, async active-low reset
//   flush            : synchronous clear (drops a concurrent push)
//   push, wdata      : write request (caller guarantees !full)
//   pop, rdata       : read request (caller guarantees !empty); rdata shows head
//   full, empty      : derived from pointer MSB comparison
//   count            : occupancy, 0..DEPTH
module act_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  import act_s2_feeder_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign count = wptr_q - rptr_q;
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/act_s2_feeder.sv
// Upstream driver for the ACT S2 logic cell.
// Commands (four data words + {A1,B1,A0,B0} + repeat count) are queued in a
// FIFO and replayed onto the cell inputs for in_rep+1 non-stalled cycles each.
//   clock, reset        : rising-edge clock, async active-low reset
//   flush               : synchronous clear of FIFO and FSM (beats stall)
//   stall               : freezes FSM/repeat counter; pushes still accepted
//   in_valid/in_ready   : command push handshake (in_ready = !full)
//   in_d00..in_d11      : command data words
//   in_sel, in_rep      : command selects and extra hold cycles
//   D00..D11, A1..B0    : registered drive to the cell
//   drv_valid           : outputs carry a live command this cycle
//   act_valid           : drv_valid delayed one cycle (cell output qualifier)
//   busy                : FSM in DRIVE
//   count               : FIFO occupancy
module act_s2_feeder #(
  parameter int unsigned BITS  = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   stall,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITS-1:0]        in_d00,
  input  logic [BITS-1:0]        in_d01,
  input  logic [BITS-1:0]        in_d10,
  input  logic [BITS-1:0]        in_d11,
  input  logic [3:0]             in_sel,
  input  logic [REP_W-1:0]       in_rep,
  output logic [BITS-1:0]        D00,
  output logic [BITS-1:0]        D01,
  output logic [BITS-1:0]        D10,
  output logic [BITS-1:0]        D11,
  output logic                   A1,
  output logic                   B1,
  output logic                   A0,
  output logic                   B0,
  output logic                   drv_valid,
  output logic                   act_valid,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  import act_s2_feeder_pkg::*;

  localparam int unsigned CMD_W = cmd_width(BITS, REP_W);
  localparam int unsigned OUT_W = 4 * BITS + 4;
  localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  logic [CMD_W-1:0] wdata, head;
  logic             fifo_full, fifo_empty, push, pop;

  state_e           state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [OUT_W-1:0] out_q, out_d;   // {sel, d11, d10, d01, d00}
  logic             drv_q, drv_d;
  logic             act_q;

  assign wdata    = {in_rep, in_sel, in_d11, in_d10, in_d01, in_d00};
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full && !flush;

  act_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    out_d   = out_q;
    drv_d   = drv_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      drv_d   = 1'b0;
      rep_d   = '0;
    end else if (!stall) begin
      if (state_q == DRIVE && rep_q != '0) begin
        rep_d = rep_q - REP_ONE;
        drv_d = 1'b1;
      end else if (!fifo_empty) begin
        // Load from IDLE or back-to-back from an expiring command.
        pop     = 1'b1;
        state_d = DRIVE;
        out_d   = head[OUT_W-1:0];
        rep_d   = head[CMD_W-1:OUT_W];
        drv_d   = 1'b1;
      end else begin
        state_d = IDLE;
        drv_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rep_q   <= '0;
      out_q   <= '0;
      drv_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      out_q   <= out_d;
      drv_q   <= drv_d;
      // Cell keeps registering through stall, so the qualifier always follows.
      act_q   <= drv_q;
    end
  end

  assign D00       = out_q[0*BITS +: BITS];
  assign D01       = out_q[1*BITS +: BITS];
  assign D10       = out_q[2*BITS +: BITS];
  assign D11       = out_q[3*BITS +: BITS];
  assign A1        = out_q[4*BITS + SEL_A1];
  assign B1        = out_q[4*BITS + SEL_B1];
  assign A0        = out_q[4*BITS + SEL_A0];
  assign B0        = out_q[4*BITS + SEL_B0];
  assign drv_valid = drv_q;
  assign act_valid = act_q;
  assign busy      = (state_q == DRIVE);

endmodule

// File: tb/tb_act_s2_feeder.sv
// Self-checking bench for act_s2_feeder: directed scenarios followed by
// randomized traffic, compared against a queue-based command model.
module tb_act_s2_feeder;

  localparam int BITS  = 2;
  localparam int DEPTH = 4;
  localparam int REP_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             stall = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BITS-1:0]  in_d00 = '0, in_d01 = '0, in_d10 = '0, in_d11 = '0;
  logic [3:0]       in_sel = '0;
  logic [REP_W-1:0] in_rep = '0;
  logic [BITS-1:0]  D00, D01, D10, D11;
  logic             A1, B1, A0, B0;
  logic             drv_valid, act_valid, busy;
  logic [CW-1:0]    count;

  act_s2_feeder #(
    .BITS  (BITS),
    .DEPTH (DEPTH),
    .REP_W (REP_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d00    (in_d00),
    .in_d01    (in_d01),
    .in_d10    (in_d10),
    .in_d11    (in_d11),
    .in_sel    (in_sel),
    .in_rep    (in_rep),
    .D00       (D00),
    .D01       (D01),
    .D10       (D10),
    .D11       (D11),
    .A1        (A1),
    .B1        (B1),
    .A0        (A0),
    .B0        (B0),
    .drv_valid (drv_valid),
    .act_valid (act_valid),
    .busy      (busy),
    .count     (count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int d00, d01, d10, d11, sel, rep;
  } cmd_t;

  cmd_t q[$];
  cmd_t m_out;
  bit   m_drv, m_act, m_active;
  int   m_left;   // drive cycles still owed to the current command, incl. this one

  task automatic model_reset();
    q.delete();
    m_out = '{0, 0, 0, 0, 0, 0};
    m_drv = 0; m_act = 0; m_active = 0; m_left = 0;
  endtask

  task automatic model_edge();
    bit   nxt_act;
    int   size0;
    bit   push_ok;
    bit   need;
    cmd_t c;
    nxt_act = m_drv;
    size0   = q.size();
    push_ok = in_valid && (size0 < DEPTH);
    if (flush) begin
      q.delete();
      m_drv = 0; m_active = 0; m_left = 0;
    end else begin
      if (!stall) begin
        need = !m_active;
        if (m_active) begin
          m_left--;
          if (m_left == 0) need = 1;
        end
        if (need) begin
          if (size0 > 0) begin
            c = q.pop_front();
            m_out = c;
            m_left = c.rep + 1;
            m_active = 1;
            m_drv = 1;
          end else begin
            m_active = 0;
            m_drv = 0;
          end
        end
      end
      if (push_ok)
        q.push_back('{int'(in_d00), int'(in_d01), int'(in_d10), int'(in_d11), int'(in_sel), int'(in_rep)});
    end
    m_act = nxt_act;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] sel;
    sel = {A1, B1, A0, B0};
    check_eq({tag, ".D00"}, 32'(D00), 32'(m_out.d00));
    check_eq({tag, ".D01"}, 32'(D01), 32'(m_out.d01));
    check_eq({tag, ".D10"}, 32'(D10), 32'(m_out.d10));
    check_eq({tag, ".D11"}, 32'(D11), 32'(m_out.d11));
    check_eq({tag, ".sel"}, 32'(sel), 32'(m_out.sel));
    check_eq({tag, ".drv_valid"}, 32'(drv_valid), 32'(m_drv));
    check_eq({tag, ".act_valid"}, 32'(act_valid), 32'(m_act));
    check_eq({tag, ".busy"}, 32'(busy), 32'(m_active));
    check_eq({tag, ".count"}, 32'(count), 32'(q.size()));
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
  endtask

  // One clock: inputs already set, advance edge, update model, sample at +1.
  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_cmd(input int d00, input int d01, input int d10, input int d11,
                         input int sel, input int rep);
    in_valid = 1'b1;
    in_d00 = BITS'(d00); in_d01 = BITS'(d01); in_d10 = BITS'(d10); in_d11 = BITS'(d11);
    in_sel = 4'(sel);    in_rep = REP_W'(rep);
  endtask

  task automatic idle(input int n, input string tag);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Async reset between edges: outputs must clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clock);
    #1;
    check_all(tag);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("por");
    reset = 1'b1;

    // Single command, rep=0, then reset mid-run
    set_cmd(1, 2, 3, 0, 4'b1010, 0); step("single");
    idle(4, "single");
    set_cmd(2, 2, 2, 2, 4'b1111, 5); step("pre_rst");
    idle(2, "pre_rst");
    async_reset("rst_mid");
    set_cmd(1, 2, 3, 0, 4'b1010, 0); step("single2");
    idle(4, "single2");

    // Repeat rep=3
    set_cmd(3, 1, 0, 2, 4'b0011, 3); step("repeat");
    idle(7, "repeat");

    // Back-to-back
    set_cmd(1, 1, 1, 1, 4'b0001, 0); step("b2b");
    set_cmd(2, 2, 2, 2, 4'b0010, 0); step("b2b");
    set_cmd(3, 3, 3, 3, 4'b0100, 0); step("b2b");
    idle(5, "b2b");

    // Full under stall, refused 5th push, drain, then wrap
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_cmd(i, i + 1, i + 2, i + 3, i + 8, 0);
      step("full");
    end
    stall = 1'b0;
    idle(7, "drain");
    for (int i = 0; i < 4; i++) begin
      set_cmd(3 - i, i, i ^ 1, i ^ 2, 15 - i, i % 2);
      step("wrap");
    end
    idle(10, "wrap");

    // Stall mid-repeat
    set_cmd(2, 3, 1, 0, 4'b0110, 2); step("stall");
    in_valid = 1'b0; step("stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall");
    stall = 1'b0;
    idle(5, "stall");

    // Flush with DRIVE active and entries queued, concurrent push dropped
    for (int i = 0; i < 4; i++) begin
      set_cmd(i, 3 - i, i, 3 - i, 5 + i, 3);
      step("pre_flush");
    end
    set_cmd(3, 3, 3, 3, 4'b1001, 1);
    flush = 1'b1; step("flush");
    flush = 1'b0;
    idle(4, "post_flush");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 99) < 60);
      in_d00 = BITS'($urandom); in_d01 = BITS'($urandom);
      in_d10 = BITS'($urandom); in_d11 = BITS'($urandom);
      in_sel = 4'($urandom);
      in_rep = REP_W'($urandom_range(0, 3));
      stall  = 1'($urandom_range(0, 99) < 25);
      flush  = 1'($urandom_range(0, 99) < 3);
      step("rand");
      if (i % 150 == 75) begin
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        async_reset("rand_rst");
      end
    end
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    idle(20, "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_s2_feeder.md
Name: act_s2_feeder

Overview:
- Upstream driver for the ACT S2 logic cell.
- Buffers configuration commands in a small FIFO. Each command holds four data words plus the A1/B1/A0/B0 select bits.
- Replays each command onto the cell's D/select inputs for a programmable number of cycles.
- Emits a valid flag delayed one cycle so downstream logic can qualify the cell's registered output.

Parameters:
- BITS, 2, width of each data word D00..D11
- DEPTH, 4, command FIFO depth; power of two, ≥2
- REP_W, 4, width of the per-command repeat count

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- flush  in  1  synchronous clear of FIFO and FSM
- stall  in  1  freezes drive FSM and repeat counter; FIFO push still allowed
- in_valid  in  1  command push request
- in_ready  out  1  FIFO can accept (= !full)
- in_d00, in_d01, in_d10, in_d11  in  BITS  data words of command
- in_sel  in  4  {A1,B1,A0,B0} of command
- in_rep  in  REP_W  extra cycles to hold command after first drive cycle
- D00, D01, D10, D11  out  BITS  registered data to ACT S2 cell
- A1, B1, A0, B0  out  1  registered selects to ACT S2 cell
- drv_valid  out  1  outputs carry a live command this cycle
- act_valid  out  1  drv_valid delayed 1 cycle; aligned with cell's registered out
- busy  out  1  state == DRIVE
- count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, async):
  - all outputs 0; drv_valid=act_valid=0
  - FIFO empty, count=0, in_ready=1, state IDLE
- Push: in_valid && in_ready at rising edge writes one entry.
  - in_ready depends only on full; a push into a full FIFO is refused even if a pop occurs in the same cycle.
- Pop: occurs only on an FSM load edge. Push and pop in the same edge → count unchanged.
- FSM states IDLE, DRIVE:
  - IDLE: on an edge with FIFO non-empty and !stall → pop head into output regs, rep_cnt<=in_rep of entry, drv_valid<=1, go DRIVE.
  - IDLE with FIFO empty → outputs hold last values, drv_valid=0.
  - DRIVE, stall=1: everything holds; drv_valid stays at its current value.
  - DRIVE, rep_cnt≠0: rep_cnt decrements; outputs hold; drv_valid=1.
  - DRIVE, rep_cnt=0, FIFO non-empty: pop next entry back-to-back with no bubble.
  - DRIVE, rep_cnt=0, FIFO empty: go IDLE, drv_valid<=0, D/select outputs retain last command.
- Each command is driven for exactly in_rep+1 non-stalled cycles.
- Latency:
  - Push at edge N into an empty FIFO while IDLE → popped at edge N+1 (drv_valid=1 after N+1).
  - act_valid=1 after N+2, coinciding with the cell's out reflecting the command.
- act_valid <= drv_valid on every edge, including during stall. This keeps act_valid aligned, since the cell keeps registering.
- flush=1 at an edge:
  - FIFO emptied, state IDLE, drv_valid<=0, rep_cnt<=0
  - concurrent push is dropped
  - D/select outputs retain their values
  - flush has priority over stall.
- Pointer wrap-around: read/write pointers are modulo DEPTH. Full/empty come from an extra MSB, not from count.
- Reset asserted mid-command: immediate return to reset values; no partial pop.

Decomposition:
- Shared package:
  - state enum {IDLE, DRIVE}
  - select-bit index constants SEL_A1=3, SEL_B1=2, SEL_A0=1, SEL_B0=0
  - command record width helper (4*BITS+4+REP_W)
- One sub-module: act_cmd_fifo, a synchronous FIFO (DEPTH, packed width).
  - ports push/pop/full/empty/count/flush, same clock/reset
  - feeder FSM and output regs stay in act_s2_feeder

Test Plan:
- Reset check: reset=0 mid-run → all outputs 0, in_ready=1, count=0 immediately. Release, then push one command (D00=1, D01=2, D10=3, D11=0, sel=4'b1010, rep=0) → drv_valid high exactly 1 cycle, act_valid 1 cycle later, outputs hold values after.
- Repeat: push sel=4'b0011, rep=3 → drv_valid high 4 consecutive cycles; A0=B0=1, A1=B1=0 throughout; busy falls on 5th edge.
- Back-to-back: push 3 commands with rep=0 on consecutive cycles → drv_valid continuous 3 cycles; outputs step through commands in order; no bubble.
- Full/wrap: with stall=1, push DEPTH=4 commands → in_ready=0, count=4. A 5th push is refused. Release stall, drain, then push 4 more → order preserved across pointer wrap.
- Stall mid-repeat: rep=2, stall for 3 cycles after first drive → command driven 3 non-stalled cycles (6 total); act_valid tracks drv_valid delayed by 1.
- Flush: 3 entries queued and DRIVE active, assert flush with in_valid=1 → next cycle count=0, drv_valid=0, state IDLE, pushed entry absent.
